ro_meas_sequencer: RTL and testbench
====================================

// Module: ro_meas_sequencer
// PURPOSE
//  Time-multiplexed frequency measurement controller for the PVT monitor's ring oscillators.
//  - Enables exactly one oscillator at a time and lets it settle.
//  - Counts its divided edges over a fixed clk-cycle gate window and publishes the count.
//  - Single sweep or continuous sweeps over all NUM_RO oscillators.
//  - Sits between the ring-oscillator instances (ena/osc_out) and the monitor readout logic.
// PARAMETERS
//  NUM_RO        4     number of ring oscillators sequenced (>=1)
//  DIV_LOG2      4     per-oscillator async prescaler, divide by 2^DIV_LOG2 (>=1)
//  SETTLE_CYCLES 16    clk cycles from ena rise to gate open (>=2)
//  GATE_CYCLES   1024  clk cycles of the counting window (>=1)
//  CNT_W         16    result counter width
// PORTS
//  clk          in   1                  system clock
//  rst_n        in   1                  asynchronous active-low reset
//  start        in   1                  level-sampled; begins a sweep when IDLE
//  continuous   in   1                  1: restart from index 0 after the last oscillator
//  abort        in   1                  stop immediately, return to IDLE
//  ro_osc       in   NUM_RO             raw oscillator outputs, asynchronous to clk
//  ro_ena       out  NUM_RO             oscillator enables, at most one bit high (one-hot or zero)
//  busy         out  1                  high in any state other than IDLE
//  result       out  CNT_W              last published edge count
//  result_idx   out  $clog2(NUM_RO)|1   oscillator index of result
//  result_ovf   out  1                  counter saturated during that window
//  result_valid out  1                  one-cycle pulse when result/result_idx/result_ovf update
//  sweep_done   out  1                  one-cycle pulse coincident with result_valid of index NUM_RO-1
// BEHAVIOUR
//  Reset (async assert, sync deassert via 2-flop):
//  - All outputs 0; state IDLE; idx 0; all prescalers cleared.
//  Prescaler:
//  - Per oscillator, DIV_LOG2-bit ripple toggle chain clocked by ro_osc[i].
//  - Async-cleared while ro_ena[i]==0 or rst_n==0.
//  - The selected chain's MSB passes through a 2-flop synchronizer into clk.
//  - Rising edge detect of the synchronizer output gives one clk-cycle tick per divided edge.
//  States:
//  - IDLE: ro_ena=0. If start=1, go to SETTLE with idx=0.
//  - SETTLE: ro_ena[idx]=1; cycle counter runs SETTLE_CYCLES cycles; ticks ignored; edge counter cleared. Then go to MEASURE.
//  - MEASURE: ro_ena[idx]=1; every tick increments the edge counter.
//    - The counter saturates at 2^CNT_W-1 and sets ovf.
//    - After GATE_CYCLES cycles, go to PUBLISH.
//  - PUBLISH (1 cycle): ro_ena=0.
//    - result<=count, result_idx<=idx, result_ovf<=ovf, result_valid=1.
//    - sweep_done=1 if idx==NUM_RO-1.
//    - Next state:
//      - idx<NUM_RO-1: SETTLE with idx+1.
//      - Else if continuous=1: SETTLE with idx=0.
//      - Else: IDLE.
//  Timing:
//  - start sampled high in IDLE at edge t: ro_ena[0] high from t+1.
//  - First result_valid occurs SETTLE_CYCLES+GATE_CYCLES+1 cycles after t.
//  - ro_ena is low for exactly one cycle between consecutive oscillators, so the prescaler clears.
//  Boundary conditions:
//  - start while busy: ignored.
//  - abort: highest priority in any state; next cycle IDLE, ro_ena=0, no result_valid.
//  - abort and start in the same cycle: abort wins.
//  - Results hold their value until the next PUBLISH; abort does not clear them.
//  - continuous sampled only in PUBLISH of the last index.
//  - NUM_RO=1: idx stays 0; sweep_done fires with every result_valid.
//  - Async reset mid-window drops ro_ena within the reset assertion, with no clk needed.
//  - Gate quantization error: +/-1 count.
// TESTING
//  1. Reset, NUM_RO=4, DIV_LOG2=4, clk 100ns, osc periods 20/25/30/40ns; start pulse, continuous=0.
//     -> four result_valid pulses with idx 0..3 and counts 320/256/213/160 (+/-1).
//     -> sweep_done with idx 3; busy then low.
//  2. Check ro_ena throughout test 1 -> never more than one bit high; one zero cycle between oscillators; first valid 1041 cycles after start.
//  3. continuous=1 for 2 sweeps, then deassert.
//     -> idx sequence 0,1,2,3,0,1,2,3; IDLE after the second sweep_done.
//  4. abort in mid-MEASURE of idx 2 -> IDLE next cycle, ro_ena=0, no result_valid, previous result (idx 1) held.
//  5. CNT_W=8, osc 20ns -> result=255, result_ovf=1.
//  6. rst_n low mid-SETTLE (between clk edges) -> ro_ena=0 and all outputs 0 immediately; start after release -> sweep begins at idx 0.

Source files
------------

// File: rtl/ro_meas_if.sv
// Control and result bundle between the ring-oscillator measurement sequencer
// and the monitor readout logic.
interface ro_meas_if #(
  parameter int unsigned NUM_RO = 4,
  parameter int unsigned CNT_W  = 16
);
  localparam int unsigned IDX_W = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;

  logic             start;
  logic             continuous;
  logic             abort;
  logic             busy;
  logic [CNT_W-1:0] result;
  logic [IDX_W-1:0] result_idx;
  logic             result_ovf;
  logic             result_valid;
  logic             sweep_done;

  modport master (
    output start, continuous, abort,
    input  busy, result, result_idx, result_ovf, result_valid, sweep_done
  );

  modport slave (
    input  start, continuous, abort,
    output busy, result, result_idx, result_ovf, result_valid, sweep_done
  );
endinterface

// File: rtl/ro_meas_sequencer.sv
// Time-multiplexed ring-oscillator frequency measurement: enables one oscillator at a time,
// lets it settle, counts its prescaled edges over a fixed clk gate window and publishes the count.
module ro_meas_sequencer #(
  parameter int unsigned NUM_RO        = 4,
  parameter int unsigned DIV_LOG2      = 4,
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned GATE_CYCLES   = 1024,
  parameter int unsigned CNT_W         = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_RO-1:0] ro_osc,
  output logic [NUM_RO-1:0] ro_ena,
  ro_meas_if.slave          bus
);

  localparam int unsigned IDX_W   = (NUM_RO > 1) ? $clog2(NUM_RO) : 1;
  localparam int unsigned CYC_MAX = (SETTLE_CYCLES > GATE_CYCLES) ? SETTLE_CYCLES : GATE_CYCLES;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CNT_W-1:0] CntMax      = '1;
  localparam logic [IDX_W-1:0] LastIdx     = IDX_W'(NUM_RO - 1);
  localparam logic [CYC_W-1:0] SettleLast  = CYC_W'(SETTLE_CYCLES - 1);
  localparam logic [CYC_W-1:0] GateLast    = CYC_W'(GATE_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StSettle, StMeasure, StPublish} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic [IDX_W-1:0] result_idx_q, result_idx_d;
  logic             result_ovf_q, result_ovf_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic             publish;

  // Reset asserts asynchronously everywhere, releases synchronously to clk.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  always_comb begin
    ro_ena = '0;
    if (rst_n && (state_q == StSettle || state_q == StMeasure)) begin
      ro_ena[idx_q] = 1'b1;
    end
  end

  // Ripple prescalers run in each oscillator's own domain and are held clear while disabled.
  logic [NUM_RO-1:0] div_msb;

  for (genvar i = 0; i < NUM_RO; i++) begin : g_presc
    logic [DIV_LOG2:0]   stg_clk;
    logic [DIV_LOG2-1:0] stg_q;

    assign stg_clk[0] = ro_osc[i];

    for (genvar k = 0; k < DIV_LOG2; k++) begin : g_stage
      logic q;

      always_ff @(posedge stg_clk[k] or negedge ro_ena[i]) begin
        if (!ro_ena[i]) begin
          q <= 1'b0;
        end else begin
          q <= ~q;
        end
      end

      assign stg_q[k]     = q;
      assign stg_clk[k+1] = ~q;
    end

    assign div_msb[i] = stg_q[DIV_LOG2-1];
  end

  logic [2:0] sync_q;
  logic       tick;

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], div_msb[idx_q]};
    end
  end

  assign tick = sync_q[1] & ~sync_q[2];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    publish = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StSettle;
          idx_d   = '0;
          cyc_d   = '0;
        end
      end
      StSettle: begin
        cnt_d = '0;
        ovf_d = 1'b0;
        if (cyc_q == SettleLast) begin
          state_d = StMeasure;
          cyc_d   = '0;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      StMeasure: begin
        if (tick) begin
          if (cnt_q == CntMax) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        if (cyc_q == GateLast) begin
          state_d = StPublish;
          cyc_d   = '0;
          publish = 1'b1;
        end else begin
          cyc_d = cyc_q + CYC_W'(1);
        end
      end
      StPublish: begin
        cyc_d = '0;
        if (idx_q != LastIdx) begin
          state_d = StSettle;
          idx_d   = idx_q + IDX_W'(1);
        end else if (bus.continuous) begin
          state_d = StSettle;
          idx_d   = '0;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (bus.abort) begin
      state_d = StIdle;
      publish = 1'b0;
    end

    // Results are registered on entry to PUBLISH so they line up with the valid pulse.
    result_d     = publish ? cnt_d : result_q;
    result_idx_d = publish ? idx_q : result_idx_q;
    result_ovf_d = publish ? ovf_d : result_ovf_q;
    valid_d      = publish;
    done_d       = publish && (idx_q == LastIdx);
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q      <= StIdle;
      idx_q        <= '0;
      cyc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      result_q     <= '0;
      result_idx_q <= '0;
      result_ovf_q <= 1'b0;
      valid_q      <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cyc_q        <= cyc_d;
      cnt_q        <= cnt_d;
      ovf_q        <= ovf_d;
      result_q     <= result_d;
      result_idx_q <= result_idx_d;
      result_ovf_q <= result_ovf_d;
      valid_q      <= valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy         = (state_q != StIdle);
  assign bus.result       = result_q;
  assign bus.result_idx   = result_idx_q;
  assign bus.result_ovf   = result_ovf_q;
  assign bus.result_valid = valid_q;
  assign bus.sweep_done   = done_q;

endmodule

// File: tb/tb_ro_meas_sequencer.sv
// Directed bench for ro_meas_sequencer: sweep results, enable sequencing, continuous mode,
// abort, asynchronous reset and counter saturation on a narrow-counter single-oscillator instance.
module tb_ro_meas_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       osc0 = 1'b0;
  logic       osc1 = 1'b0;
  logic       osc2 = 1'b0;
  logic       osc3 = 1'b0;
  logic [3:0] ro_osc;
  logic [3:0] ro_ena;
  logic [0:0] ro_ena8;

  int unsigned cyc = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  int          viol = 0;

  ro_meas_if #(.NUM_RO(4), .CNT_W(16)) bus ();
  ro_meas_if #(.NUM_RO(1), .CNT_W(8))  bus8 ();

  ro_meas_sequencer #(
    .NUM_RO(4), .DIV_LOG2(4), .SETTLE_CYCLES(16), .GATE_CYCLES(1024), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .ro_osc(ro_osc), .ro_ena(ro_ena), .bus(bus)
  );

  ro_meas_sequencer #(
    .NUM_RO(1), .DIV_LOG2(4), .SETTLE_CYCLES(16), .GATE_CYCLES(1024), .CNT_W(8)
  ) dut8 (
    .clk(clk), .rst_n(rst_n), .ro_osc(osc0), .ro_ena(ro_ena8), .bus(bus8)
  );

  // clk period 100; oscillator periods 20/25/30/40 in the same time unit.
  always #50 clk = ~clk;
  always #10 osc0 = ~osc0;
  always begin
    #12 osc1 = 1'b1;
    #13 osc1 = 1'b0;
  end
  always #15 osc2 = ~osc2;
  always #20 osc3 = ~osc3;
  assign ro_osc = {osc3, osc2, osc1, osc0};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if ($countones(ro_ena) > 1) viol <= viol + 1;
  end

  typedef struct {
    bit start_in;
    bit cont;
    int exp_idx;
    int exp_cnt;
    bit exp_done;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input bit ok, input longint act, input longint exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(output bit got, output logic [3:0] last_ena);
    int n;
    got = 1'b0;
    n = 0;
    last_ena = ro_ena;
    while (!got && n < 3000) begin
      @(negedge clk);
      if (bus.result_valid) got = 1'b1;
      else last_ena = ro_ena;
      n++;
    end
  endtask

  initial begin
    bit          got;
    bit          was_busy;
    logic [3:0]  last_ena;
    logic [3:0]  exp_ena;
    int unsigned c_t;
    int          n;
    int          pulses;
    logic [15:0] res1;
    int          cnts[4];

    cnts[0] = 320;
    cnts[1] = 256;
    cnts[2] = 213;
    cnts[3] = 160;
    // Single sweep (start also pulsed mid-sweep, must be ignored), then two continuous sweeps.
    for (int v = 0; v < 12; v++) begin
      vecs[v].exp_idx  = v % 4;
      vecs[v].exp_cnt  = cnts[v % 4];
      vecs[v].exp_done = ((v % 4) == 3);
      vecs[v].start_in = (v == 0 || v == 2 || v == 4);
      vecs[v].cont     = (v >= 4 && v <= 10);
    end

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.continuous = 1'b0;
    bus.abort = 1'b0;
    bus8.start = 1'b0;
    bus8.continuous = 1'b0;
    bus8.abort = 1'b0;
    c_t = 0;

    repeat (3) @(negedge clk);
    check("rst_ena", ro_ena == 4'b0, ro_ena, 0);
    check("rst_busy", bus.busy == 1'b0, bus.busy, 0);
    check("rst_outs", {bus.result, bus.result_idx, bus.result_ovf, bus.result_valid,
                       bus.sweep_done} == '0, bus.result, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int v = 0; v < 12; v++) begin
      bus.continuous = vecs[v].cont;
      if (vecs[v].start_in) begin
        was_busy = bus.busy;
        bus.start = 1'b1;
        if (v == 0) c_t = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        if (!was_busy) begin
          check("start_ena0", ro_ena == 4'b0001, ro_ena, 1);
          check("start_busy", bus.busy == 1'b1, bus.busy, 1);
        end
      end
      wait_valid(got, last_ena);
      check("valid_seen", got, got, 1);
      if (got) begin
        if (v == 0) check("first_latency", (cyc - c_t) == 1041, cyc - c_t, 1041);
        check("res_idx", bus.result_idx == 2'(vecs[v].exp_idx), bus.result_idx,
              vecs[v].exp_idx);
        check("res_cnt", (int'(bus.result) >= vecs[v].exp_cnt - 1) &&
              (int'(bus.result) <= vecs[v].exp_cnt + 1), bus.result, vecs[v].exp_cnt);
        check("res_ovf", bus.result_ovf == 1'b0, bus.result_ovf, 0);
        check("sweep_done", bus.sweep_done == vecs[v].exp_done, bus.sweep_done,
              vecs[v].exp_done);
        check("ena_gap", ro_ena == 4'b0, ro_ena, 0);
        exp_ena = 4'b0001 << vecs[v].exp_idx;
        check("ena_before", last_ena == exp_ena, last_ena, exp_ena);
        @(negedge clk);
        check("valid_pulse", bus.result_valid == 1'b0, bus.result_valid, 0);
        if (vecs[v].exp_idx < 3 || vecs[v].cont) begin
          exp_ena = 4'b0001 << ((vecs[v].exp_idx + 1) % 4);
          check("busy_next", bus.busy == 1'b1, bus.busy, 1);
        end else begin
          exp_ena = 4'b0;
          check("busy_next", bus.busy == 1'b0, bus.busy, 0);
        end
        check("ena_after", ro_ena == exp_ena, ro_ena, exp_ena);
      end
    end

    // Abort mid-MEASURE of idx 2: previous idx 1 result must be held.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_valid(got, last_ena);
    @(negedge clk);
    wait_valid(got, last_ena);
    check("abort_pre_idx", got && bus.result_idx == 2'd1, bus.result_idx, 1);
    res1 = bus.result;
    n = 0;
    while (ro_ena != 4'b0100 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("abort_reach_idx2", ro_ena == 4'b0100, ro_ena, 4);
    repeat (16 + 500) @(negedge clk);
    check("abort_pre_busy", bus.busy == 1'b1, bus.busy, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check("abort_busy", bus.busy == 1'b0, bus.busy, 0);
    check("abort_ena", ro_ena == 4'b0, ro_ena, 0);
    check("abort_valid", bus.result_valid == 1'b0, bus.result_valid, 0);
    check("abort_hold_idx", bus.result_idx == 2'd1, bus.result_idx, 1);
    check("abort_hold_res", bus.result == res1, bus.result, res1);

    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    check("abort_start_busy", bus.busy == 1'b0, bus.busy, 0);
    check("abort_start_ena", ro_ena == 4'b0, ro_ena, 0);
    pulses = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (bus.result_valid || bus.busy) pulses++;
    end
    check("abort_quiet", pulses == 0, pulses, 0);

    // Asynchronous reset between clk edges during SETTLE.
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_pre_busy", bus.busy == 1'b1, bus.busy, 1);
    #20;
    rst_n = 1'b0;
    #1;
    check("arst_ena", ro_ena == 4'b0, ro_ena, 0);
    check("arst_busy", bus.busy == 1'b0, bus.busy, 0);
    check("arst_res", bus.result == 16'd0, bus.result, 0);
    check("arst_outs", {bus.result_idx, bus.result_ovf, bus.result_valid, bus.sweep_done} == '0,
          bus.result_idx, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("arst_restart_ena", ro_ena == 4'b0001, ro_ena, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;

    // 8-bit counter on a 20-period oscillator saturates; single oscillator ends every sweep.
    bus8.start = 1'b1;
    @(negedge clk);
    bus8.start = 1'b0;
    check("ovf_ena", ro_ena8 == 1'b1, ro_ena8, 1);
    got = 1'b0;
    n = 0;
    while (!got && n < 3000) begin
      @(negedge clk);
      got = bus8.result_valid;
      n++;
    end
    check("ovf_valid_seen", got, got, 1);
    check("ovf_res", bus8.result == 8'd255, bus8.result, 255);
    check("ovf_flag", bus8.result_ovf == 1'b1, bus8.result_ovf, 1);
    check("ovf_done", bus8.sweep_done == 1'b1, bus8.sweep_done, 1);
    check("ovf_idx", bus8.result_idx == 1'b0, bus8.result_idx, 0);
    @(negedge clk);
    check("ovf_idle", bus8.busy == 1'b0, bus8.busy, 0);

    check("ena_onehot", viol == 0, viol, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
